// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-side bundle for the branch resolve unit.
// The unit takes the slave modport. The pipeline side takes the master modport.
interface branch_resolve_unit_if #(
    parameter int CNT_W = 32
);
    logic              pred_valid;
    logic              stall;
    logic              pred_taken;
    logic [31:0]       pred_pc;
    logic [31:0]       pred_target;
    logic              res_valid;
    logic              res_taken;
    logic [31:0]       res_target;
    logic              q_full;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic              underflow;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  mispred_cnt;

    modport master (
        output pred_valid, stall, pred_taken, pred_pc, pred_target,
               res_valid, res_taken, res_target,
        input  q_full, upd_valid, upd_pc, upd_taken, flush, redirect_pc,
               underflow, branch_cnt, mispred_cnt
    );

    modport slave (
        input  pred_valid, stall, pred_taken, pred_pc, pred_target,
               res_valid, res_taken, res_target,
        output q_full, upd_valid, upd_pc, upd_taken, flush, redirect_pc,
               underflow, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver. It keeps an in-order queue of fetch predictions and checks each one at resolution.
// On every resolution it trains the predictor. On a wrong prediction it flushes fetch with the corrected PC.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } rec_t;

    localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

    rec_t             rec_q [DEPTH];
    rec_t             rec_d [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             count_q, count_d;
    logic             upd_valid_q, upd_valid_d;
    logic [31:0]      upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    rec_t             head;
    logic             pop;
    logic             push;
    logic             mispredict;
    logic             kill;
    logic [31:0]      correct_pc;

    always_comb begin
        head       = rec_q[rd_ptr_q];
        pop        = bus.res_valid && (count_q != '0);
        mispredict = (head.taken != bus.res_taken) ||
                     (bus.res_taken && head.taken && (head.target != bus.res_target));
        kill       = pop && mispredict;
        correct_pc = bus.res_taken ? bus.res_target : head.pc + 32'd4;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push       = bus.pred_valid && !bus.stall && !flush_q && !kill &&
                     ((count_q != FULL_COUNT) || pop);

        rec_d = rec_q;
        if (push) begin
            rec_d[wr_ptr_q] = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end

        upd_valid_d   = pop;
        upd_pc_d      = pop ? head.pc : upd_pc_q;
        upd_taken_d   = pop ? bus.res_taken : upd_taken_q;
        flush_d       = kill;
        redirect_pc_d = kill ? correct_pc : redirect_pc_q;
        underflow_d   = underflow_q || (bus.res_valid && (count_q == '0));

        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (pop && (branch_cnt_q != '1))  branch_cnt_d  = branch_cnt_q + CNT_W'(1);
        if (kill && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            underflow_q   <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            rec_q         <= rec_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            underflow_q   <= underflow_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.q_full      = (count_q == FULL_COUNT);
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_pc      = upd_pc_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.underflow   = underflow_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. A vector table drives the unit and a scoreboard checks each predictor update.
// A second instance with 2-bit counters shares the same inputs and is used to check counter saturation.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.CNT_W(32)) bus ();
    branch_resolve_unit_if #(.CNT_W(2))  bus2 ();

    branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    branch_resolve_unit #(.DEPTH(4), .CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus2.pred_valid  = bus.pred_valid;
    assign bus2.stall       = bus.stall;
    assign bus2.pred_taken  = bus.pred_taken;
    assign bus2.pred_pc     = bus.pred_pc;
    assign bus2.pred_target = bus.pred_target;
    assign bus2.res_valid   = bus.res_valid;
    assign bus2.res_taken   = bus.res_taken;
    assign bus2.res_target  = bus.res_target;

    typedef struct {
        logic        pv;
        logic        ptk;
        logic [31:0] ppc;
        logic [31:0] ptgt;
        logic        stall;
        logic        rv;
        logic        rtk;
        logic [31:0] rtgt;
        logic        e_upd;
        logic [31:0] e_pc;
        logic        e_tk;
        logic        e_fl;
        logic [31:0] e_rd;
        logic        e_full;
        logic        e_uf;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic        fl;
        logic [31:0] rd;
    } upd_t;

    vec_t        vecs[$];
    upd_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_branch = 0;
    int          exp_mis = 0;

    function automatic vec_t mkVec(
        input logic pv, input logic ptk, input logic [31:0] ppc, input logic [31:0] ptgt,
        input logic stall, input logic rv, input logic rtk, input logic [31:0] rtgt,
        input logic e_upd, input logic [31:0] e_pc, input logic e_tk, input logic e_fl,
        input logic [31:0] e_rd, input logic e_full, input logic e_uf);
        vec_t v;
        v.pv = pv;       v.ptk = ptk;     v.ppc = ppc;     v.ptgt = ptgt;
        v.stall = stall; v.rv = rv;       v.rtk = rtk;     v.rtgt = rtgt;
        v.e_upd = e_upd; v.e_pc = e_pc;   v.e_tk = e_tk;   v.e_fl = e_fl;
        v.e_rd = e_rd;   v.e_full = e_full; v.e_uf = e_uf;
        return v;
    endfunction

    function automatic logic [31:0] sat2(input int n);
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        upd_t e;
        checkVal("q_full", 32'(bus.q_full), 32'(v.e_full));
        checkVal("underflow", 32'(bus.underflow), 32'(v.e_uf));
        checkVal("branch_cnt", bus.branch_cnt, 32'(exp_branch));
        checkVal("mispred_cnt", bus.mispred_cnt, 32'(exp_mis));
        checkVal("sat_branch_cnt", 32'(bus2.branch_cnt), sat2(exp_branch));
        checkVal("sat_mispred_cnt", 32'(bus2.mispred_cnt), sat2(exp_mis));
        if (bus.upd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL upd_unexpected: got upd_valid=1 pc=0x%08h, expected upd_valid=0", bus.upd_pc);
            end else begin
                e = sb.pop_front();
                checkVal("upd_pc", bus.upd_pc, e.pc);
                checkVal("upd_taken", 32'(bus.upd_taken), 32'(e.tk));
                checkVal("flush", 32'(bus.flush), 32'(e.fl));
                if (e.fl) checkVal("redirect_pc", bus.redirect_pc, e.rd);
            end
        end else begin
            checks++;
            if (v.e_upd) begin
                failures++;
                $display("[TB] FAIL upd_missing: got upd_valid=0, expected upd_valid=1 pc=0x%08h", v.e_pc);
                if (sb.size() != 0) void'(sb.pop_front());
            end
            checkVal("flush_idle", 32'(bus.flush), 32'd0);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        upd_t e;
        @(negedge clk);
        if (v.pv && !v.stall) begin
            checks++;
            if (bus.q_full && !v.rv) begin
                failures++;
                $display("[TB] FAIL push_while_full: got q_full=1 with pred_valid, expected q_full=0");
            end
        end
        bus.pred_valid  = v.pv;
        bus.pred_taken  = v.ptk;
        bus.pred_pc     = v.ppc;
        bus.pred_target = v.ptgt;
        bus.stall       = v.stall;
        bus.res_valid   = v.rv;
        bus.res_taken   = v.rtk;
        bus.res_target  = v.rtgt;
        if (v.e_upd) begin
            e.pc = v.e_pc; e.tk = v.e_tk; e.fl = v.e_fl; e.rd = v.e_rd;
            sb.push_back(e);
            exp_branch++;
            if (v.e_fl) exp_mis++;
        end
        @(posedge clk);
        #1;
        checkOutput(v);
    endtask

    function automatic logic [31:0] wrapPc(input int i);
        return 32'h1000 + 32'(i) * 32'h10;
    endfunction

    initial begin
        vec_t idle;
        idle = mkVec(0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0);

        // Correct taken prediction
        vecs.push_back(mkVec(1,1,32'h100,32'h200,0, 0,0,0,           0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(0,0,0,0,0,             1,1,32'h200,     1,32'h100,1,0,0, 0,0));
        // Predicted taken, resolved not-taken; then target mismatch; then pc+4 wrap
        vecs.push_back(mkVec(1,1,32'h300,32'h380,0, 0,0,0,           0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(0,0,0,0,0,             1,0,0,           1,32'h300,0,1,32'h304, 0,0));
        vecs.push_back(idle);
        vecs.push_back(mkVec(1,1,32'h480,32'h500,0, 0,0,0,           0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(0,0,0,0,0,             1,1,32'h600,     1,32'h480,1,1,32'h600, 0,0));
        vecs.push_back(idle);
        vecs.push_back(mkVec(1,1,32'hFFFF_FFFC,32'h40,0, 0,0,0,      0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(0,0,0,0,0,             1,0,0,           1,32'hFFFF_FFFC,0,1,32'h0, 0,0));
        vecs.push_back(idle);
        // Fill to DEPTH, stream with simultaneous push/pop, then drain
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec(1,0,wrapPc(i),0,0, 0,0,0, 0,0,0,0,0, (i == 3),0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mkVec(1,0,wrapPc(k+4),0,0, 1,0,0, 1,wrapPc(k),0,0,0, 1,0));
        for (int k = 6; k < 10; k++)
            vecs.push_back(mkVec(0,0,0,0,0, 1,0,0, 1,wrapPc(k),0,0,0, 0,0));
        // Stalled push must not enter the queue
        vecs.push_back(mkVec(1,0,32'h700,0,1, 0,0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(1,0,32'h710,0,0, 0,0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(0,0,0,0,0,       1,0,0, 1,32'h710,0,0,0, 0,0));
        // Direction mispredict with younger records, pushes gated by kill and by flush
        vecs.push_back(mkVec(1,0,32'h100,0,0, 0,0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(1,0,32'h110,0,0, 0,0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(1,0,32'h120,0,0, 0,0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(1,0,32'h130,0,0, 1,1,32'h400, 1,32'h100,1,1,32'h400, 0,0));
        vecs.push_back(mkVec(1,0,32'h140,0,0, 0,0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mkVec(0,0,0,0,0,       1,0,0, 0,0,0,0,0, 0,1));
        vecs.push_back(mkVec(0,0,0,0,0,       0,0,0, 0,0,0,0,0, 0,1));
        // Three records queued ahead of the mid-stream reset
        vecs.push_back(mkVec(1,0,32'h800,0,0, 0,0,0, 0,0,0,0,0, 0,1));
        vecs.push_back(mkVec(1,0,32'h810,0,0, 0,0,0, 0,0,0,0,0, 0,1));
        vecs.push_back(mkVec(1,0,32'h820,0,0, 0,0,0, 0,0,0,0,0, 0,1));

        bus.pred_valid = 0; bus.pred_taken = 0; bus.pred_pc = 0; bus.pred_target = 0;
        bus.stall = 0; bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;

        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_q_full", 32'(bus.q_full), 0);
        checkVal("rst_upd_valid", 32'(bus.upd_valid), 0);
        checkVal("rst_upd_pc", bus.upd_pc, 0);
        checkVal("rst_flush", 32'(bus.flush), 0);
        checkVal("rst_redirect_pc", bus.redirect_pc, 0);
        checkVal("rst_underflow", 32'(bus.underflow), 0);
        checkVal("rst_branch_cnt", bus.branch_cnt, 0);
        checkVal("rst_mispred_cnt", bus.mispred_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Mispredicting resolution presented, then reset asserted before it can be clocked
        @(negedge clk);
        bus.pred_valid = 0;
        bus.res_valid  = 1;
        bus.res_taken  = 1;
        bus.res_target = 32'h900;
        #2 rst_n = 1'b0;
        #1;
        checkVal("async_upd_valid", 32'(bus.upd_valid), 0);
        checkVal("async_flush", 32'(bus.flush), 0);
        checkVal("async_underflow", 32'(bus.underflow), 0);
        checkVal("async_branch_cnt", bus.branch_cnt, 0);
        checkVal("async_mispred_cnt", bus.mispred_cnt, 0);
        checkVal("async_upd_pc", bus.upd_pc, 0);
        checkVal("async_q_full", 32'(bus.q_full), 0);
        bus.res_valid = 0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkVal("post_rst_flush", 32'(bus.flush), 0);
        checkVal("post_rst_upd_valid", 32'(bus.upd_valid), 0);
        checkVal("post_rst_underflow", 32'(bus.underflow), 0);
        exp_branch = 0;
        exp_mis = 0;
        sb.delete();

        // Stale records must be gone: the next pop must see the fresh push
        applyStimulus(mkVec(1,1,32'hA00,32'hA80,0, 0,0,0,       0,0,0,0,0, 0,0));
        applyStimulus(mkVec(0,0,0,0,0,             1,1,32'hA80, 1,32'hA00,1,0,0, 0,0));
        applyStimulus(idle);

        checkVal("scoreboard_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
